// File: rtl/test_pkg_a.sv
// Shared types for the hero write receive path.
//   HERO_WIDTH    : width of the hero write data bus
//   CYCLE_TYPE_E  : hero bus cycle encoding (4 bits; 3..15 are illegal)
//   hero_write_t  : hero write bus {cycle_type, wdat, clk_en}
//   rx_state_e    : receive FSM states
//   rx_entry_t    : FIFO entry {err, last, dat}
package test_pkg_a;

    localparam int HERO_WIDTH = 8;

    typedef enum logic [3:0] {
        _E_IDLE  = 4'd0,
        _E_VALID = 4'd1,
        _E_DONE  = 4'd2
    } CYCLE_TYPE_E;

    typedef struct packed {
        CYCLE_TYPE_E           cycle_type;
        logic [HERO_WIDTH-1:0] wdat;
        logic                  clk_en;
    } hero_write_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic                  err;
        logic                  last;
        logic [HERO_WIDTH-1:0] dat;
    } rx_entry_t;

    localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/hero_rx_fifo.sv
// Synchronous FIFO with registered storage.
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push/push_dat : write request; ignored when full unless popping the same cycle
//   pop        : read request; ignored when empty
//   head_dat   : current head entry, straight from storage flops
//   full/empty/count : occupancy status
module hero_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == DEPTH_CNT);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: frames VALID/DONE beats into transactions and
// queues them as {err, last, dat} beats for a valid/ready consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   hero_wr    : hero write bus (no backpressure)
//   out_vld/out_rdy/out_dat/out_last/out_err : downstream beat stream
//   txn_cnt    : transactions delivered (beats transferred with out_last=1)
//   ovf_err/len_err/proto_err : sticky error flags, cleared by err_clr
module hero_write_rx
    import test_pkg_a::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  hero_write_t           hero_wr,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [HERO_WIDTH-1:0] out_dat,
    output logic                  out_last,
    output logic                  out_err,
    output logic [15:0]           txn_cnt,
    output logic                  ovf_err,
    output logic                  len_err,
    output logic                  proto_err,
    input  logic                  err_clr
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

    rx_state_e       state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            term_pend_q, term_pend_d;
    logic [15:0]     txn_cnt_q, txn_cnt_d;
    logic            ovf_q, ovf_d, len_q, len_d, proto_q, proto_d;

    logic            beat, is_done, illegal;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty, space;
    rx_entry_t       push_ent, head;
    logic            ovf_set, len_set;
    logic [$clog2(DEPTH):0] fifo_count;

    assign is_done = (hero_wr.cycle_type == _E_DONE);
    assign beat    = hero_wr.clk_en &&
                     (hero_wr.cycle_type == _E_VALID || hero_wr.cycle_type == _E_DONE);
    assign illegal = hero_wr.clk_en &&
                     !(hero_wr.cycle_type inside {_E_IDLE, _E_VALID, _E_DONE});

    // Outputs come only from FIFO flops; zeroed while empty.
    assign out_vld  = !fifo_empty;
    assign out_dat  = fifo_empty ? '0 : head.dat;
    assign out_last = !fifo_empty && head.last;
    assign out_err  = !fifo_empty && head.err;
    assign fifo_pop = out_vld && out_rdy;
    // A slot frees up this cycle if the head is being consumed.
    assign space    = !fifo_full || fifo_pop;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        term_pend_d = term_pend_q;
        fifo_push   = 1'b0;
        push_ent    = '0;
        ovf_set     = 1'b0;
        len_set     = 1'b0;

        // Pending terminator owns the free slot ahead of any incoming beat.
        if (term_pend_q && space) begin
            fifo_push     = 1'b1;
            push_ent.err  = 1'b1;
            push_ent.last = 1'b1;
            term_pend_d   = 1'b0;
        end

        if (beat) begin
            if (state_q == ST_DROP) begin
                if (is_done) state_d = ST_IDLE;
            end else if (fifo_push || !space) begin
                // No slot for this beat: abandon the transaction and owe a
                // terminator. Later drops before it lands share the same one.
                ovf_set     = 1'b1;
                term_pend_d = 1'b1;
                state_d     = is_done ? ST_IDLE : ST_DROP;
            end else begin
                fifo_push    = 1'b1;
                push_ent.dat = hero_wr.wdat;
                if (state_q == ST_IDLE) begin
                    beat_cnt_d    = BW'(1);
                    push_ent.last = is_done;
                    state_d       = is_done ? ST_IDLE : ST_ACTIVE;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (is_done) begin
                        push_ent.last = 1'b1;
                        state_d       = ST_IDLE;
                    end else if (beat_cnt_q + 1'b1 == MAX_CNT) begin
                        // Length limit reached: close it out as errored and
                        // swallow the remainder up to DONE.
                        push_ent.last = 1'b1;
                        push_ent.err  = 1'b1;
                        len_set       = 1'b1;
                        state_d       = ST_DROP;
                    end
                end
            end
        end

        txn_cnt_d = txn_cnt_q;
        if (fifo_pop && head.last) txn_cnt_d = txn_cnt_q + 16'd1;

        // Set wins over a same-cycle clear.
        ovf_d   = (ovf_q   && !err_clr) || ovf_set;
        len_d   = (len_q   && !err_clr) || len_set;
        proto_d = (proto_q && !err_clr) || illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            term_pend_q <= 1'b0;
            txn_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            len_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            term_pend_q <= term_pend_d;
            txn_cnt_q   <= txn_cnt_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
            proto_q     <= proto_d;
        end
    end

    assign txn_cnt   = txn_cnt_q;
    assign ovf_err   = ovf_q;
    assign len_err   = len_q;
    assign proto_err = proto_q;

    logic [RX_ENTRY_W-1:0] head_raw;
    assign head = rx_entry_t'(head_raw);

    hero_rx_fifo #(
        .WIDTH(RX_ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .push_dat(push_ent),
        .pop     (fifo_pop),
        .head_dat(head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_hero_write_rx.sv
module tb_hero_write_rx;
    import test_pkg_a::*;

    logic        clk = 1'b0;
    logic        rst_n;
    hero_write_t hero_wr;
    logic        out_vld, out_rdy, out_last, out_err;
    logic [7:0]  out_dat;
    logic [15:0] txn_cnt;
    logic        ovf_err, len_err, proto_err, err_clr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] cap[$];   // {err, last, dat} of each transferred beat

    hero_write_rx #(.DEPTH(8), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n), .hero_wr(hero_wr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .out_last(out_last), .out_err(out_err), .txn_cnt(txn_cnt),
        .ovf_err(ovf_err), .len_err(len_err), .proto_err(proto_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && out_vld && out_rdy) cap.push_back({out_err, out_last, out_dat});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input CYCLE_TYPE_E ct, input logic [7:0] d, input logic en);
        hero_wr.cycle_type = ct;
        hero_wr.wdat       = d;
        hero_wr.clk_en     = en;
        @(posedge clk); #1;
        hero_wr = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (out_vld && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", {31'd0, out_vld}, 32'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_txn;
        rst_n   = 1'b0;
        hero_wr = '0;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        tick(3);

        // Reset state
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_dat", {24'd0, out_dat}, 32'd0);
        chk("rst_out_last_err", {30'd0, out_last, out_err}, 32'd0);
        chk("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        chk("rst_flags", {29'd0, ovf_err, len_err, proto_err}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        exp_txn = 0;

        // Lone DONE: one-cycle latency, holds while stalled
        chk("lone_pre_vld", {31'd0, out_vld}, 32'd0);
        drive(_E_DONE, 8'h5A, 1'b1);
        chk("lone_lat_vld", {31'd0, out_vld}, 32'd1);
        chk("lone_head", {22'd0, out_err, out_last, out_dat}, {22'd0, 10'h15A});
        tick(2);
        chk("lone_hold", {22'd0, out_err, out_last, out_dat}, {22'd0, 10'h15A});
        out_rdy = 1'b1;
        drain();
        exp_txn++;
        chk("lone_n", cap.size(), 32'd1);
        if (cap.size() == 1) chk("lone_beat", {22'd0, cap[0]}, {22'd0, 10'h15A});
        chk("lone_txn", {16'd0, txn_cnt}, exp_txn);

        // 3 VALID + DONE streaming
        cap.delete();
        drive(_E_VALID, 8'h11, 1'b1);
        drive(_E_VALID, 8'h22, 1'b1);
        drive(_E_VALID, 8'h33, 1'b1);
        drive(_E_DONE,  8'h44, 1'b1);
        drain();
        exp_txn++;
        chk("basic_n", cap.size(), 32'd4);
        if (cap.size() == 4) begin
            chk("basic_b0", {22'd0, cap[0]}, {22'd0, 10'h011});
            chk("basic_b1", {22'd0, cap[1]}, {22'd0, 10'h022});
            chk("basic_b2", {22'd0, cap[2]}, {22'd0, 10'h033});
            chk("basic_b3", {22'd0, cap[3]}, {22'd0, 10'h144});
        end
        chk("basic_txn", {16'd0, txn_cnt}, exp_txn);
        chk("basic_flags", {29'd0, ovf_err, len_err, proto_err}, 32'd0);

        // 18 VALID + DONE with MAX_BEATS=16
        cap.delete();
        for (int i = 1; i <= 18; i++) drive(_E_VALID, 8'(i), 1'b1);
        drive(_E_DONE, 8'hEE, 1'b1);
        drain();
        exp_txn++;
        chk("len_n", cap.size(), 32'd16);
        for (int i = 0; i < 15 && i < cap.size(); i++)
            chk("len_beat", {22'd0, cap[i]}, {22'd0, 2'b00, 8'(i + 1)});
        if (cap.size() >= 16) chk("len_b16", {22'd0, cap[15]}, {22'd0, 10'h310});
        chk("len_err", {31'd0, len_err}, 32'd1);
        chk("len_txn", {16'd0, txn_cnt}, exp_txn);
        // FSM back in IDLE: a lone DONE is a normal one-beat transaction
        cap.delete();
        drive(_E_DONE, 8'h77, 1'b1);
        drain();
        exp_txn++;
        chk("len_idle_n", cap.size(), 32'd1);
        if (cap.size() == 1) chk("len_idle_beat", {22'd0, cap[0]}, {22'd0, 10'h177});
        pulse_clr();
        chk("clr_flags", {29'd0, ovf_err, len_err, proto_err}, 32'd0);

        // Overflow: stall, 10 VALID + DONE into an 8-deep FIFO
        cap.delete();
        out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) drive(_E_VALID, 8'hA0 + 8'(i), 1'b1);
        drive(_E_DONE, 8'hAF, 1'b1);
        chk("ovf_flag", {31'd0, ovf_err}, 32'd1);
        out_rdy = 1'b1;
        drain();
        exp_txn++;
        chk("ovf_n", cap.size(), 32'd9);
        for (int i = 0; i < 8 && i < cap.size(); i++)
            chk("ovf_beat", {22'd0, cap[i]}, {22'd0, 2'b00, 8'hA0 + 8'(i)});
        if (cap.size() >= 9) chk("ovf_term", {22'd0, cap[8]}, {22'd0, 10'h300});
        chk("ovf_txn", {16'd0, txn_cnt}, exp_txn);

        // Ignored inputs and protocol errors
        pulse_clr();
        cap.delete();
        drive(_E_VALID, 8'h99, 1'b0);
        tick(2);
        chk("noen_vld", {31'd0, out_vld}, 32'd0);
        chk("noen_proto", {31'd0, proto_err}, 32'd0);
        drive(CYCLE_TYPE_E'(4'd7), 8'h12, 1'b1);
        tick(2);
        chk("ill_vld", {31'd0, out_vld}, 32'd0);
        chk("ill_proto", {29'd0, ovf_err, len_err, proto_err}, 32'd1);
        pulse_clr();
        chk("ill_clr", {29'd0, ovf_err, len_err, proto_err}, 32'd0);
        err_clr = 1'b1;
        drive(CYCLE_TYPE_E'(4'd15), 8'h34, 1'b1);
        err_clr = 1'b0;
        chk("set_wins", {31'd0, proto_err}, 32'd1);
        pulse_clr();
        chk("no_push_cap", cap.size(), 32'd0);

        // Reset mid-transaction
        out_rdy = 1'b0;
        drive(_E_VALID, 8'h01, 1'b1);
        drive(_E_VALID, 8'h02, 1'b1);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_vld", {31'd0, out_vld}, 32'd0);
        chk("mrst_txn", {16'd0, txn_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        cap.delete();
        out_rdy = 1'b1;
        drive(_E_DONE, 8'h3C, 1'b1);
        drain();
        chk("mrst_n", cap.size(), 32'd1);
        if (cap.size() == 1) chk("mrst_beat", {22'd0, cap[0]}, {22'd0, 10'h13C});
        chk("mrst_txn2", {16'd0, txn_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
